// File: rtl/sram_mem_controller.sv
// MEM-stage data-memory responder: each 32-bit word request becomes two
// 16-bit accesses on an external asynchronous SRAM, with ready low until done.
module sram_mem_controller #(
    parameter int unsigned LATENCY   = 6,
    parameter int unsigned DATA_BASE = 1024,
    parameter int unsigned SRAM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned IDX_W     = SRAM_AW - 1;
    localparam int unsigned WAIT_LAST = (LATENCY > 4) ? LATENCY - 5 : 0;

    typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  wcnt, wcnt_next;
    logic        op_wr;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] read_buf, read_buf_next;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        req;
    logic [IDX_W-1:0] idx;

    assign req = mem_r_en | mem_w_en;
    // Word index relative to the data segment; wraps for addresses below the base.
    assign idx = IDX_W'((addr_q - 32'(DATA_BASE)) >> 2);

    assign sram_dq   = dq_oe ? dq_out : 16'bz;
    assign sram_oe_n = 1'b0;
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign ready = ((state == IDLE) && !req) || (state == DONE);

    // Next-state, SRAM bus control and read capture.
    always_comb begin
        state_next    = state;
        wcnt_next     = wcnt;
        read_buf_next = read_buf;
        sram_we_n     = 1'b1;
        sram_addr     = '0;
        dq_oe         = 1'b0;
        dq_out        = '0;
        case (state)
            IDLE: begin
                if (req) state_next = LOW;
            end
            LOW: begin
                sram_addr = {idx, 1'b0};
                if (op_wr) begin
                    sram_we_n = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = wdata_q[15:0];
                end else begin
                    read_buf_next[15:0] = sram_dq;
                end
                state_next = HIGH;
            end
            HIGH: begin
                sram_addr = {idx, 1'b1};
                if (op_wr) begin
                    sram_we_n = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = wdata_q[31:16];
                end else begin
                    read_buf_next[31:16] = sram_dq;
                end
                wcnt_next  = 4'd0;
                state_next = (LATENCY > 4) ? WAIT : DONE;
            end
            WAIT: begin
                if (wcnt == 4'(WAIT_LAST)) state_next = DONE;
                else                       wcnt_next  = wcnt + 4'd1;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; request fields latched only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= 4'd0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_buf  <= '0;
            read_data <= '0;
        end else begin
            state    <= state_next;
            wcnt     <= wcnt_next;
            read_buf <= read_buf_next;
            if ((state == IDLE) && req) begin
                op_wr   <= mem_w_en;
                addr_q  <= address;
                wdata_q <= write_data;
            end
            // Update on entry to DONE so the word is visible during the DONE cycle.
            if ((state_next == DONE) && !op_wr) read_data <= read_buf_next;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: word-level reference model plus scoreboard
// monitor on the default instance, and a short directed run at LATENCY=4.
module tb_sram_mem_controller;

    localparam int unsigned LAT  = 6;
    localparam int unsigned BASE = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r_en, w_en;
    logic [31:0] addr, wdata;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    logic        r4, w4;
    logic [31:0] a4, d4;
    logic [31:0] read_data4;
    logic        ready4;
    wire  [15:0] sram_dq4;
    logic [17:0] sram_addr4;
    logic        sram_we_n4, sram_oe_n4, sram_ce_n4, sram_ub_n4, sram_lb_n4;

    sram_mem_controller #(.LATENCY(LAT), .DATA_BASE(BASE), .SRAM_AW(18)) u_dut (
        .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en),
        .address(addr), .write_data(wdata), .read_data(read_data), .ready(ready),
        .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    sram_mem_controller #(.LATENCY(4), .DATA_BASE(BASE), .SRAM_AW(18)) u_dut4 (
        .clk(clk), .rst(rst), .mem_r_en(r4), .mem_w_en(w4),
        .address(a4), .write_data(d4), .read_data(read_data4), .ready(ready4),
        .sram_dq(sram_dq4), .sram_addr(sram_addr4), .sram_we_n(sram_we_n4),
        .sram_oe_n(sram_oe_n4), .sram_ce_n(sram_ce_n4), .sram_ub_n(sram_ub_n4),
        .sram_lb_n(sram_lb_n4)
    );

    // Asynchronous SRAM models: drive when not being written, capture while we_n low.
    logic [15:0] sram  [0:1023];
    logic [15:0] sram4 [0:15];
    assign sram_dq  = sram_we_n  ? sram[sram_addr[9:0]]   : 16'hzzzz;
    assign sram_dq4 = sram_we_n4 ? sram4[sram_addr4[3:0]] : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n)  sram[sram_addr[9:0]]   <= sram_dq;
    always @(posedge clk) if (!sram_we_n4) sram4[sram_addr4[3:0]] <= sram_dq4;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 32-bit words keyed by byte address, zero when never written.
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // Monitor: a rise of ready after busy cycles marks one completed access.
    int          low_cnt = 0;
    int          we_cnt  = 0;
    logic [31:0] exp_rd  = 32'h0;
    exp_t        e;
    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0;
            we_cnt  = 0;
            exp_rd  = 32'h0;
        end else begin
            if (!ready) begin
                low_cnt++;
                if (!sram_we_n) we_cnt++;
            end else begin
                if (low_cnt != 0) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got completion expected none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("latency", 32'(low_cnt), 32'(LAT - 1));
                        check("we_n_cycles", 32'(we_cnt), e.is_read ? 32'd0 : 32'd2);
                        if (e.is_read) exp_rd = e.data;
                    end
                end
                low_cnt = 0;
                we_cnt  = 0;
                check("addr_when_ready", 32'(sram_addr), 32'h0);
            end
            check("read_data", read_data, exp_rd);
        end
    end

    task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        r_en  = r;
        w_en  = w;
        addr  = a;
        wdata = d;
    endtask

    // Present a request in IDLE and return just after the accepting edge.
    task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        drive(r, w, a, d);
        x.is_read = r && !w;
        if (w) begin
            ref_mem[a] = d;
            x.data     = d;
        end else begin
            x.data = ref_read(a);
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (ready) break;
            k++;
        end
        if (k >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no ready expected ready within 40 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_scramble();
        drive(1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic lat4_txn(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, output int cnt);
        r4 = r; w4 = w; a4 = a; d4 = d;
        cnt = 0;
        @(negedge clk);
        if (!ready4) cnt++;
        @(posedge clk);
        #1;
        r4 = 1'b0; w4 = 1'b0; a4 = $urandom; d4 = $urandom;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready4) break;
            cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        logic [31:0] d;
        logic [31:0] a;
        int          op;

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        r4 = 1'b0; w4 = 1'b0; a4 = 32'h0; d4 = 32'h0;
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0;
        for (int i = 0; i < 16; i++) sram4[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("tied_pins", 32'({sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}), 32'h0);
        @(posedge clk);
        #1;

        // Write then read back the same word, then a write that must not touch read_data.
        issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        idle_scramble();
        wait_done();
        check("sram2", 32'(sram[2]), 32'h0000BEEF);
        check("sram3", 32'(sram[3]), 32'h0000DEAD);
        issue(1'b1, 1'b0, 32'd1028, $urandom);
        idle_scramble();
        wait_done();
        repeat (3) begin @(posedge clk); #1; end
        issue(1'b0, 1'b1, 32'd1032, $urandom);
        idle_scramble();
        wait_done();

        // Back-to-back: the read is held asserted through the write.
        issue(1'b0, 1'b1, 32'd1024, 32'h12345678);
        drive(1'b1, 1'b0, 32'd1024, $urandom);
        wait_done();
        issue(1'b1, 1'b0, 32'd1024, $urandom);
        idle_scramble();
        wait_done();
        check("sram0", 32'(sram[0]), 32'h00005678);
        check("sram1", 32'(sram[1]), 32'h00001234);

        // Both enables high behaves as a write.
        issue(1'b1, 1'b1, 32'd1036, 32'h0000FFFF);
        idle_scramble();
        wait_done();
        check("sram6", 32'(sram[6]), 32'h0000FFFF);
        check("sram7", 32'(sram[7]), 32'h00000000);

        // Reset during WAIT of a read with the request still asserted.
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("read_data_after_rst", read_data, 32'h0);
        @(posedge clk); #1;
        idle_scramble();
        wait_done();

        // Randomized reads, writes and dual-enable requests over a small window.
        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 2));
            a  = BASE + 4 * $urandom_range(0, 63);
            d  = $urandom;
            issue(op != 1, op != 0, a, d);
            idle_scramble();
            wait_done();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        repeat (2) begin @(posedge clk); #1; end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        // LATENCY=4 instance: no WAIT state, three freeze cycles.
        d = $urandom;
        lat4_txn(1'b0, 1'b1, 32'd1024, d, c);
        check("lat4_write_latency", 32'(c), 32'd3);
        check("lat4_read_data_after_write", read_data4, 32'h0);
        lat4_txn(1'b1, 1'b0, 32'd1024, $urandom, c);
        check("lat4_read_latency", 32'(c), 32'd3);
        check("lat4_read_data", read_data4, d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
Responder side of the MEM-stage data-memory interface. It accepts 32-bit word read/write requests from the MEM stage, carried on mem_r_en, mem_w_en, address and write data. It performs each request as two 16-bit accesses on an external asynchronous SRAM. It holds ready low until the access completes, and the top level ORs ~ready into the pipeline freeze.

Parameters:
LATENCY, 6, cycles from request acceptance to the ready-high cycle inclusive; legal range 4 to 16
DATA_BASE, 1024, byte address that maps to SRAM word 0
SRAM_AW, 18, SRAM address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
mem_r_en  input  1  read request from MEM stage
mem_w_en  input  1  write request from MEM stage
address  input  32  byte address (ALU result)
write_data  input  32  store data (Val_Rm)
read_data  output  32  loaded word; registered
ready  output  1  1 = no access pending or access completing this cycle
sram_dq  inout  16  SRAM data bus
sram_addr  output  SRAM_AW  SRAM half-word address
sram_we_n  output  1  SRAM write enable, active low
sram_oe_n  output  1  tied 0
sram_ce_n  output  1  tied 0
sram_ub_n  output  1  tied 0
sram_lb_n  output  1  tied 0

Behaviour:
- FSM states: IDLE, LOW, HIGH, WAIT, DONE. A wait counter wcnt [3:0] serves WAIT.
- ready is combinational: ready = (state==IDLE & ~(mem_r_en|mem_w_en)) | (state==DONE).
  - ready drops in the same cycle a request appears in IDLE.
  - ready is 0 in LOW, HIGH and WAIT.
- Acceptance happens in IDLE with (mem_r_en|mem_w_en)=1.
  - The controller latches op, address and write_data, then goes to LOW.
  - If both enables are high, the write wins.
- Address mapping:
  - idx = (address - DATA_BASE) >> 2, using 32-bit wrap-around subtraction, truncated to SRAM_AW-1 bits.
  - LOW drives sram_addr = {idx,0}; HIGH drives sram_addr = {idx,1}.
- LOW state:
  - Write: sram_we_n=0 and sram_dq=wdata[15:0].
  - Read: the bus is Z, and read_buf[15:0] <= sram_dq at the exiting clock edge.
  - Next state is HIGH.
- HIGH state:
  - Same as LOW, using wdata[31:16] and read_buf[31:16].
  - Next state is WAIT if LATENCY>4, otherwise DONE.
  - wcnt is loaded with 0.
- WAIT state: wcnt increments each cycle; leave to DONE when wcnt==LATENCY-5, giving LATENCY-4 WAIT cycles.
- DONE state:
  - ready=1.
  - On a read, read_data <= read_buf, registered at entry so the value is valid in the DONE cycle.
  - Next state is IDLE unconditionally.
  - A new request therefore cannot be accepted earlier than the cycle after DONE.
- Latency: a request first visible in cycle N gives ready=0 for cycles N..N+LATENCY-2 (LATENCY-1 cycles) and ready=1 in cycle N+LATENCY-1. Default: 5 freeze cycles.
- Latched request fields are the only source during an access; input changes after acceptance are ignored.
- read_data holds its value until the next read reaches DONE. A write never alters read_data.
- SRAM bus rules:
  - sram_dq is driven only in LOW/HIGH of a write; otherwise it is Z.
  - sram_we_n=1 outside write LOW/HIGH.
  - sram_addr=0 in IDLE, WAIT and DONE.
- Reset (any state):
  - state=IDLE, wcnt=0, read_data=0, read_buf=0, latched fields=0.
  - sram_we_n=1, dq Z.
  - ready follows the formula, so it is 1 unless a request is present.
  - An aborted write may leave a half-written SRAM word; this is accepted.
  - A request still asserted after rst falls is accepted in the first post-reset cycle.
- No request (both enables 0): stays in IDLE, ready=1, SRAM idle.

Test Plan:
- Write 0xDEADBEEF to 1028, LATENCY=6 -> idx=1; SRAM[2]=0xBEEF in LOW, SRAM[3]=0xDEAD in HIGH; we_n low exactly 2 cycles; ready low 5 cycles then high 1 cycle.
- Read 1028 after the previous write -> read_data=0xDEADBEEF in the DONE cycle and held through 3 idle cycles; a subsequent write to 1032 leaves read_data unchanged.
- Back-to-back: write 0x12345678 to 1024, then a read of 1024 held asserted -> second access accepted in the cycle after DONE; read returns 0x12345678; SRAM[0]=0x5678, SRAM[1]=0x1234.
- LATENCY=4: read 1024 -> no WAIT state; ready low 3 cycles, high in 4th; data correct.
- rst asserted during the WAIT of a read of 1028 with rd_en still high -> after reset read_data=0; access restarts; completes with the correct value 5 cycles after acceptance.
- mem_r_en=mem_w_en=1, address 1036, data 0x0000FFFF -> performed as a write: SRAM[6]=0xFFFF, SRAM[7]=0x0000; read_data unchanged.
